// File: rtl/dsp_arb_pkg.sv
// Shared types and helpers for the DSP shared-resource arbiters.
// Optional feature macro used by vmul_arbiter: VMUL_ARB_LOCK_EN.
package dsp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 16;

    // Upper bounds for the generic slice helper below.
    localparam int MAX_NREQ  = 8;
    localparam int MAX_WIDTH = 64;

    // Extract lane idx (w bits wide) from a packed operand bus.
    function automatic logic [MAX_WIDTH-1:0] op_slice(
        input logic [MAX_NREQ*MAX_WIDTH-1:0] opbus,
        input int unsigned                   idx,
        input int unsigned                   w
    );
        logic [MAX_WIDTH-1:0] mask;
        mask = (w >= MAX_WIDTH) ? '1
                                : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
        return MAX_WIDTH'(opbus >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/vmul_arbiter_if.sv
// Requester, multiplier and response bundle of vmul_arbiter.
// req_lock exists only when VMUL_ARB_LOCK_EN is defined.
interface vmul_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
`ifdef VMUL_ARB_LOCK_EN
    logic [NREQ-1:0]       req_lock;
`endif
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_p;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;
    logic                  rsp_ready;
    logic                  busy;

    // Environment side: requesters, multiplier and response consumer.
    modport master (
`ifdef VMUL_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
        input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
    );

    // Arbiter side.
    modport slave (
`ifdef VMUL_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
        output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface

// File: rtl/vmul_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority picker. The search starts
// one past last_i and wraps; the first set request bit wins.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_i,
    output logic [IDW-1:0] win_o,
    output logic           any_o
);
    // Walk from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        int idx;
        win_o = '0;
        any_o = |req_i;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N;
            if (req_i[idx]) win_o = IDW'(idx);
        end
    end
endmodule

// File: rtl/vmul_arbiter.sv
// vmul_arbiter: round-robin sharing of one multi-cycle multiplier among
// NREQ requesters; one operation in flight, tagged response channel.
// Optional sticky-grant lock: define VMUL_ARB_LOCK_EN.
module vmul_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input logic            clk,
    input logic            nrst,
    vmul_arbiter_if.slave  bus
);
    localparam int BUSW = MAX_NREQ * MAX_WIDTH;

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d;

    logic [IDW-1:0]     rr_win, win;
    logic               rr_any;

    rr_picker #(.N(NREQ), .IDW(IDW)) u_pick (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .win_o  (rr_win),
        .any_o  (rr_any)
    );

`ifdef VMUL_ARB_LOCK_EN
    logic           lock_vld_q, lock_vld_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    // A live lock whose owner is still requesting overrides round-robin.
    always_comb begin
        win = rr_win;
        if (lock_vld_q && bus.req_valid[lock_id_q]) win = lock_id_q;
    end
`else
    assign win = rr_win;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            last_q   <= IDW'(NREQ - 1);
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            rsp_id_q <= '0;
            rsp_p_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            rsp_id_q <= rsp_id_d;
            rsp_p_q  <= rsp_p_d;
        end
    end

`ifdef VMUL_ARB_LOCK_EN
    // Lock registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end
`endif

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_p_d       = rsp_p_q;
        bus.req_ready = '0;
        bus.mul_start = 1'b0;
        bus.rsp_valid = 1'b0;
`ifdef VMUL_ARB_LOCK_EN
        lock_vld_d    = lock_vld_q;
        lock_id_d     = lock_id_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef VMUL_ARB_LOCK_EN
                // Owner stopped requesting: release the lock.
                if (lock_vld_q && !bus.req_valid[lock_id_q]) lock_vld_d = 1'b0;
`endif
                if (rr_any) begin
                    bus.req_ready = NREQ'(1) << win;
                    mul_a_d  = WIDTH'(op_slice(BUSW'(bus.req_a), 32'(win), WIDTH));
                    mul_b_d  = WIDTH'(op_slice(BUSW'(bus.req_b), 32'(win), WIDTH));
                    rsp_id_d = win;
                    state_d  = ISSUE;
`ifdef VMUL_ARB_LOCK_EN
                    lock_vld_d = bus.req_lock[win];
                    lock_id_d  = win;
`endif
                end
            end
            ISSUE: begin
                bus.mul_start = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    rsp_p_d = bus.mul_p;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    last_d  = rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mul_a  = mul_a_q;
    assign bus.mul_b  = mul_b_q;
    assign bus.rsp_id = rsp_id_q;
    assign bus.rsp_p  = rsp_p_q;
    assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_vmul_arbiter.sv
// Self-checking bench for vmul_arbiter: requester drivers, a multiplier
// model with programmable latency and a response scoreboard.
// The lock scenario runs only when VMUL_ARB_LOCK_EN is defined.
module tb_vmul_arbiter;
    import dsp_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]     id;
        logic [2*WIDTH-1:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    vmul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    vmul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    int                 n_chk, n_pass;
    int                 cyc;
    int                 want [NREQ];
    logic               lock_want [NREQ];
    logic [WIDTH-1:0]   op_a [NREQ];
    logic [WIDTH-1:0]   op_b [NREQ];
    int                 mul_lat;
    exp_t               exp_q [$];
    int                 gq [$];
    int                 rsp_cnt, rise_cnt;
    int                 acc_cyc, start_cyc, rise_cyc;
    logic               prev_rv;
    logic               stall_chk;
    logic [2*WIDTH-1:0] last_p;
    logic [WIDTH-1:0]   ma, mb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: valid follows the outstanding count per requester.
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
`ifdef VMUL_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i]          = (want[i] > 0);
                bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
                bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
`ifdef VMUL_ARB_LOCK_EN
                bus.req_lock[i]           = lock_want[i] && (want[i] > 1);
`endif
            end
        end
    end

    // Multiplier model: done arrives mul_lat+1 cycles after the start cycle.
    initial begin
        bus.mul_done = 1'b0;
        bus.mul_p    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mul_start) begin
                ma = bus.mul_a;
                mb = bus.mul_b;
                repeat (mul_lat + 1) @(posedge clk);
                #1;
                bus.mul_done = 1'b1;
                bus.mul_p    = (2*WIDTH)'(ma) * (2*WIDTH)'(mb);
                @(posedge clk);
                #1;
                bus.mul_done = 1'b0;
                bus.mul_p    = '0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        int   id;
        exp_t e;
        if (nrst) begin
            if (bus.req_ready != '0) begin
                id = 0;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) id = i;
                chk("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                e.id = IDW'(id);
                e.p  = (2*WIDTH)'(op_a[id]) * (2*WIDTH)'(op_b[id]);
                exp_q.push_back(e);
                gq.push_back(id);
                want[id] = want[id] - 1;
                acc_cyc  = cyc;
            end
            if (bus.mul_start) start_cyc = cyc;
            if (bus.rsp_valid && !prev_rv) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (stall_chk && exp_q.size() > 0) begin
                chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
                chk("stall_id", 64'(bus.rsp_id), 64'(exp_q[0].id));
                chk("stall_p", 64'(bus.rsp_p), 64'(exp_q[0].p));
                chk("stall_no_ready", 64'(bus.req_ready), 64'd0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rsp_p", 64'(bus.rsp_p), 64'(e.p));
                    last_p = bus.rsp_p;
                end
                rsp_cnt++;
            end
        end
        prev_rv = bus.rsp_valid;
    end

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({pfx, "_mul_start"}, 64'(bus.mul_start), 64'd0);
        chk({pfx, "_mul_a"},     64'(bus.mul_a),     64'd0);
        chk({pfx, "_mul_b"},     64'(bus.mul_b),     64'd0);
        chk({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({pfx, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
        chk({pfx, "_rsp_p"},     64'(bus.rsp_p),     64'd0);
        chk({pfx, "_busy"},      64'(bus.busy),      64'd0);
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (rsp_cnt < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk("rsp_count", 64'(rsp_cnt), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nrst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        int g0, r0, t;
        int ord2 [5] = '{0, 1, 2, 3, 0};
        int ord6 [8] = '{3, 0, 1, 2, 2, 2, 2, 3};
        bus.rsp_ready = 1'b0;
        stall_chk     = 1'b0;
        mul_lat       = 2;
        for (int i = 0; i < NREQ; i++) begin
            want[i] = 0; lock_want[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
        end
        #2 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        nrst = 1'b1;

        // Single request, latency 2.
        op_a[0] = 16'd3; op_b[0] = 16'd5;
        bus.rsp_ready = 1'b1;
        want[0] = 1;
        wait_rsp(1);
        chk("t1_grants", 64'(gq.size()), 64'd1);
        chk("t1_grant0", 64'(gq[0]), 64'd0);
        chk("t1_start_lat", 64'(start_cyc - acc_cyc), 64'd1);
        chk("t1_rsp_lat", 64'(rise_cyc - acc_cyc), 64'd5);
        chk("t1_prod", 64'(last_p), 64'd15);

        // All four requesting from reset: round-robin order.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'(i + 1); op_b[i] = 16'd10;
        end
        g0 = gq.size();
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        wait_rsp(rsp_cnt + 5);
        for (int k = 0; k < 5; k++) chk("t2_order", 64'(gq[g0 + k]), 64'(ord2[k]));

        // Consumer stall in RESP with another request pending.
        bus.rsp_ready = 1'b0;
        g0 = gq.size();
        r0 = rsp_cnt;
        want[1] = 1; want[2] = 1;
        t = 0;
        while (!bus.rsp_valid && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("t3_reached_resp", 64'(bus.rsp_valid), 64'd1);
        stall_chk = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        stall_chk = 1'b0;
        chk("t3_one_grant", 64'(gq.size() - g0), 64'd1);
        bus.rsp_ready = 1'b1;
        wait_rsp(r0 + 2);
        chk("t3_order0", 64'(gq[g0]), 64'd1);
        chk("t3_order1", 64'(gq[g0 + 1]), 64'd2);

        // Reset while waiting on the multiplier; late done must be ignored.
        mul_lat = 10;
        g0 = gq.size();
        want[3] = 1;
        t = 0;
        while (gq.size() == g0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t4_busy_wait", 64'(bus.busy), 64'd1);
        nrst = 1'b0;
        #1;
        check_reset_vals("t4");
        exp_q.delete();
        r0 = rise_cnt;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("t4_no_rsp", 64'(rise_cnt - r0), 64'd0);
        chk("t4_idle", 64'(bus.busy), 64'd0);
        mul_lat = 2;
        g0 = gq.size();
        r0 = rsp_cnt;
        want[0] = 1; want[3] = 1;
        wait_rsp(r0 + 2);
        chk("t4_first_after_rst", 64'(gq[g0]), 64'd0);
        chk("t4_second", 64'(gq[g0 + 1]), 64'd3);

        // Full-scale operands.
        op_a[2] = 16'hFFFF; op_b[2] = 16'hFFFF;
        want[2] = 1;
        wait_rsp(rsp_cnt + 1);
        chk("t5_max", 64'(last_p), 64'hFFFE0001);

`ifdef VMUL_ARB_LOCK_EN
        // Requester 2 holds the lock for its first three wins.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'(i + 1); op_b[i] = 16'd10;
        end
        lock_want[2] = 1'b1;
        g0 = gq.size();
        want[0] = 1; want[1] = 1; want[2] = 4; want[3] = 2;
        wait_rsp(rsp_cnt + 8);
        for (int k = 0; k < 8; k++) chk("t6_lock_order", 64'(gq[g0 + k]), 64'(ord6[k]));
        lock_want[2] = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vmul_arbiter.md
# vmul_arbiter

Shares one multi-cycle Vedic multiplier between up to NREQ requesters in the DSP processor, e.g. the ALU multiply path, a MAC/FIR sequencer and a debug port. Requesters use a valid/ready handshake. The block picks a winner round-robin, issues its operands to the external multiplier, waits for completion, and returns the product on one shared response channel tagged with the requester id. Exactly one operation is in flight at a time.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand width; the product is 2*WIDTH.
- IDW, $clog2(NREQ): requester id width.
- clk  in  1  system clock; all state on its rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot acceptance pulse.
- mul_start  out  1  one-cycle start strobe to the multiplier.
- mul_a, mul_b  out  WIDTH  operands to the multiplier, held stable from start until done.
- mul_done  in  1  one-cycle completion strobe from the multiplier.
- mul_p  in  2*WIDTH  product; valid while mul_done is high.
- rsp_valid  out  1  response available.
- rsp_id  out  IDW  id of the requester that owns the response.
- rsp_p  out  2*WIDTH  product.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid bit is high, select winner w by round-robin. Search starts at last_grant+1 mod NREQ and takes the first set bit.
  - Same cycle: req_ready[w]=1 (combinational from registered state and req_valid).
  - Clock edge: latch req_a/req_b slice w into mul_a/mul_b, latch w into rsp_id, go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on mul_done, register mul_p into rsp_p and go to RESP. mul_done in any other state is ignored.
- RESP: rsp_valid=1 and held with rsp_id/rsp_p stable until rsp_ready is sampled high. On that edge: last_grant<=rsp_id, go to IDLE.
- A requester must hold req_valid and its operands stable until it sees req_ready. Dropping req_valid before grant is legal: it withdraws the request.
- Simultaneous requests: only the winner is acknowledged. Other requests stay pending and are not lost.
- rsp_ready high outside RESP has no effect.
- No internal timeout. A multiplier that never asserts mul_done stalls the block in WAIT until reset.

## Timing
- Reset values: state=IDLE; last_grant=NREQ-1, so requester 0 wins first after reset; mul_a=mul_b=0; rsp_id=0; rsp_p=0; req_ready=0; mul_start=0; rsp_valid=0; busy=0.
- Reset asserted mid-operation: the in-flight operation is dropped and the FSM returns to IDLE. A later mul_done is ignored because the state is no longer WAIT.
- Cycle c is the accept cycle (req_ready high). Then mul_start is high at c+1. The earliest mul_done is c+2, and rsp_valid rises at c+3 at the earliest.
- Latency is therefore 3 cycles plus multiplier latency plus consumer stall.
- The next accept happens no earlier than the cycle after the response handshake.
- The product passes through unmodified: no truncation, no signedness handling. Operands are unsigned, matching the Vedic multiplier.

## Configuration
- VMUL_ARB_LOCK_EN defined:
  - Adds input port req_lock, width NREQ.
  - If req_lock[w] is high in the accept cycle, a lock bit is set for w. In the next IDLE visit, w wins whenever req_valid[w]=1, bypassing round-robin.
  - The lock clears when w is in IDLE with req_valid[w]=0, or when w wins again with req_lock[w]=0.
  - The lock clears on reset.
- VMUL_ARB_LOCK_EN undefined: the req_lock port and lock logic are absent, and arbitration is pure round-robin.

## Structure
- Package dsp_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - default NREQ/WIDTH localparams;
  - a function that extracts slice i from a packed operand bus.
- Sub-module rr_picker: a combinational round-robin priority picker. Inputs are the request vector and last_grant; outputs are the winner index and an any-valid flag. It is reused later by other shared-resource arbiters.

## Test plan
- Reset, then req_valid=4'b0001, A=3, B=5, multiplier latency 2, rsp_ready=1:
  - req_ready[0] pulses once;
  - mul_start is high one cycle later;
  - rsp_valid is high with rsp_id=0, rsp_p=15 at accept+5.
- req_valid=4'b1111 held continuously, each requester i driving A=i+1, B=10, rsp_ready=1:
  - grant order is 0,1,2,3,0;
  - products are 10, 20, 30, 40.
- rsp_ready=0 for 6 cycles in RESP:
  - rsp_valid, rsp_id and rsp_p stay stable;
  - no new req_ready pulse occurs until the handshake completes.
- nrst low while in WAIT, then mul_done pulses after release:
  - all outputs are at reset values;
  - rsp_valid stays 0;
  - the next grant goes to requester 0.
- A=B=0xFFFF with WIDTH=16: rsp_p=0xFFFE0001.
- With VMUL_ARB_LOCK_EN, requester 2 asserts req_lock while req_valid=4'b1111:
  - requester 2 wins consecutively until it drops req_lock;
  - round-robin then resumes at requester 3.
